// File: rtl/map_pkg.sv
// Shared tile-map definitions: tile codes, map geometry and the probe FSM states.
package map_pkg;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        WALL   = 3'd1,
        BRICK  = 3'd2,
        BASE_A = 3'd3,
        BASE_B = 3'd4
    } tile_t;

    localparam int MAP_COLS   = 20;
    localparam int MAP_ROWS   = 15;
    localparam int TILE_SHIFT = 5;
    localparam int MAP_CELLS  = 300;
    localparam logic [8:0] OFFSCREEN_IDX = 9'd511;

    // Last on-screen pixel coordinates (640x480 playfield).
    localparam logic [10:0] SCREEN_X_MAX = 11'd639;
    localparam logic [10:0] SCREEN_Y_MAX = 11'd479;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROBE = 2'd1,
        S_DONE  = 2'd2
    } probe_state_t;

endpackage

// File: rtl/tile_index.sv
// Pixel coordinate to tile-map index; flags coordinates outside the playfield.
module tile_index
    import map_pkg::*;
(
    input  logic [10:0] px_i,
    input  logic [10:0] py_i,
    output logic [8:0]  idx_o,
    output logic        offscreen_o
);

    logic [8:0] col;
    logic [8:0] row;

    assign col         = 9'(px_i >> TILE_SHIFT);
    assign row         = 9'(py_i >> TILE_SHIFT);
    assign offscreen_o = (px_i > SCREEN_X_MAX) || (py_i > SCREEN_Y_MAX);

    // In range, row <= 14 and col <= 19, so the product fits in 9 bits.
    always_comb begin
        idx_o = row * 9'(MAP_COLS) + col;
        if (offscreen_o) idx_o = OFFSCREEN_IDX;
    end

endmodule

// File: rtl/tile_probe.sv
// Four-corner sprite collision probe against the tile map, one corner per cycle.
module tile_probe
    import map_pkg::*;
#(
    parameter int SPRITE_W = 28
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  tile_t [MAP_CELLS-1:0]  map_i,
    input  logic                   req_i,
    input  logic [9:0]             pos_x_i,
    input  logic [9:0]             pos_y_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   blocked_o,
    output logic [8:0]             hit_index_o,
    output tile_t                  hit_tile_o
);

    localparam logic [10:0] EXT = 11'(SPRITE_W - 1);

    probe_state_t state_q;
    logic [1:0]   cnt_q;
    logic [9:0]   pos_x_q, pos_y_q;
    logic         found_q, found_d;
    logic [8:0]   acc_idx_q, acc_idx_d;
    tile_t        acc_tile_q, acc_tile_d;
    logic         busy_q, done_q, blocked_q;
    logic [8:0]   hit_idx_q;
    tile_t        hit_tile_q;

    logic [10:0]  corner_x, corner_y;
    logic [8:0]   corner_idx, safe_idx;
    logic         corner_off, corner_blk;
    tile_t        corner_tile;

    // cnt_q bit 0 selects the right edge, bit 1 the bottom edge: TL, TR, BL, BR.
    assign corner_x = {1'b0, pos_x_q} + (cnt_q[0] ? EXT : 11'd0);
    assign corner_y = {1'b0, pos_y_q} + (cnt_q[1] ? EXT : 11'd0);

    tile_index u_index (
        .px_i        (corner_x),
        .py_i        (corner_y),
        .idx_o       (corner_idx),
        .offscreen_o (corner_off)
    );

    always_comb begin
        safe_idx    = corner_off ? 9'd0 : corner_idx;
        corner_tile = corner_off ? WALL : map_i[safe_idx];
        corner_blk  = (corner_tile != EMPTY);

        found_d    = found_q | corner_blk;
        acc_idx_d  = acc_idx_q;
        acc_tile_d = acc_tile_q;
        if (!found_q && corner_blk) begin
            acc_idx_d  = corner_idx;
            acc_tile_d = corner_tile;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            pos_x_q    <= 10'd0;
            pos_y_q    <= 10'd0;
            found_q    <= 1'b0;
            acc_idx_q  <= 9'd0;
            acc_tile_q <= EMPTY;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            blocked_q  <= 1'b0;
            hit_idx_q  <= 9'd0;
            hit_tile_q <= EMPTY;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (req_i) begin
                        state_q    <= S_PROBE;
                        busy_q     <= 1'b1;
                        cnt_q      <= 2'd0;
                        pos_x_q    <= pos_x_i;
                        pos_y_q    <= pos_y_i;
                        found_q    <= 1'b0;
                        acc_idx_q  <= 9'd0;
                        acc_tile_q <= EMPTY;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_PROBE: begin
                    found_q    <= found_d;
                    acc_idx_q  <= acc_idx_d;
                    acc_tile_q <= acc_tile_d;
                    cnt_q      <= cnt_q + 2'd1;
                    // Results publish only on the final corner so outputs hold across a probe.
                    if (cnt_q == 2'd3) begin
                        state_q    <= S_DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        blocked_q  <= found_d;
                        hit_idx_q  <= acc_idx_d;
                        hit_tile_q <= acc_tile_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign blocked_o   = blocked_q;
    assign hit_index_o = hit_idx_q;
    assign hit_tile_o  = hit_tile_q;

endmodule
